// File: rtl/enokida_trace_buffer.sv
// Elastic trace-packet FIFO feeding the enokida_dm cache: registered head output,
// capture gating, lock-drop accounting, flush and saturating statistics.
module enokida_trace_buffer #(
  parameter int TRACE_WIDTH = 160,
  parameter int DEPTH       = 8,
  parameter int PTR_WIDTH   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tracer_valid_i,
  input  logic [TRACE_WIDTH-1:0] tracer_data_i,
  input  logic                   trace_capture_enable,
  input  logic                   lock,
  input  logic                   flush_i,
  input  logic                   trace_pop_i,
  output logic [TRACE_WIDTH-1:0] trace_in,
  output logic                   trace_ready,
  output logic                   full_o,
  output logic [PTR_WIDTH:0]     occupancy_o,
  output logic [31:0]            push_count,
  output logic [31:0]            drop_count,
  output logic [PTR_WIDTH:0]     high_water
);

  localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH:0]   CNT_ONE    = (PTR_WIDTH+1)'(1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                 state, state_next;
  logic                   flush_clear;
  logic [TRACE_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr, rd_ptr, rd_ptr_next;
  logic [PTR_WIDTH:0]     count_next;
  logic [TRACE_WIDTH-1:0] head_next;
  logic                   push_req, push_acc, pop_eff, drop;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      RUN:     if (flush_i)  state_next = FLUSH;
      FLUSH:   if (!flush_i) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // The clear lands on the edge that samples flush_i, so a one-cycle flush
  // leaves the following cycle free for normal traffic.
  always_comb begin
    flush_clear = 1'b0;
    case (state)
      RUN:     flush_clear = flush_i;
      FLUSH:   flush_clear = flush_i;
      default: flush_clear = 1'b0;
    endcase
  end

  assign trace_ready = (occupancy_o != '0);
  assign full_o      = (occupancy_o == FULL_COUNT);

  assign push_req = tracer_valid_i & trace_capture_enable;
  assign pop_eff  = trace_pop_i & trace_ready & ~flush_clear;
  assign push_acc = push_req & ~lock & (~full_o | pop_eff) & ~flush_clear;
  assign drop     = push_req & ~push_acc & ~flush_clear;

  always_comb begin
    count_next = occupancy_o;
    case ({push_acc, pop_eff})
      2'b10:   count_next = occupancy_o + CNT_ONE;
      2'b01:   count_next = occupancy_o - CNT_ONE;
      default: count_next = occupancy_o;
    endcase
  end

  assign rd_ptr_next = pop_eff ? rd_ptr + PTR_ONE : rd_ptr;

  // The new head may be the very packet being written on this edge.
  assign head_next = (push_acc && (wr_ptr == rd_ptr_next)) ? tracer_data_i : mem[rd_ptr_next];

  // NOTE: packet storage has no reset; only pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= tracer_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occupancy_o <= '0;
      high_water  <= '0;
      trace_in    <= '0;
    end else if (flush_clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occupancy_o <= '0;
      high_water  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr      <= rd_ptr_next;
      occupancy_o <= count_next;
      if (count_next > high_water) high_water <= count_next;
      if (count_next != '0)        trace_in   <= head_next;
    end
  end

  // Statistics saturate instead of wrapping; flush leaves them alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_count <= '0;
      drop_count <= '0;
    end else begin
      if (push_acc && (push_count != 32'hFFFF_FFFF)) push_count <= push_count + 32'd1;
      if (drop && (drop_count != 32'hFFFF_FFFF))     drop_count <= drop_count + 32'd1;
    end
  end

endmodule

// File: doc/enokida_trace_buffer.md
Name: enokida_trace_buffer

Overview:
Elastic FIFO between the instruction/memory tracer and the enokida_dm trace-assisted cache. It captures 160-bit trace packets from the tracer and presents the oldest one to the cache on trace_in/trace_ready. Packets are removed with a one-cycle pop strobe from the cache. It also supports capture gating, lock suppression, flush, and saturating statistics counters.

Parameters:
TRACE_WIDTH, 160, trace packet width; must match the cache trace_in width.
DEPTH, 8, number of FIFO entries; power of two, minimum 2.
PTR_WIDTH, 3, log2(DEPTH).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
tracer_valid_i  input  1  tracer presents a packet this cycle.
tracer_data_i  input  TRACE_WIDTH  packet from tracer.
trace_capture_enable  input  1  push permitted only while high.
lock  input  1  cache lock; while high, pushes are refused and counted as dropped.
flush_i  input  1  discard all buffered packets.
trace_pop_i  input  1  cache consumes the head packet.
trace_in  output  TRACE_WIDTH  head packet, to cache trace_in.
trace_ready  output  1  head packet valid (FIFO not empty).
full_o  output  1  FIFO full.
occupancy_o  output  PTR_WIDTH+1  current entry count, 0..DEPTH.
push_count  output  32  packets accepted.
drop_count  output  32  packets refused (full or lock).
high_water  output  PTR_WIDTH+1  maximum occupancy since reset or flush.

Behaviour:
- Reset (async, rst=1): pointers=0, occupancy_o=0, trace_ready=0, full_o=0, trace_in=0, push_count=0, drop_count=0, high_water=0. FSM enters RUN. Storage contents are don't-care.
- Push request = tracer_valid_i & trace_capture_enable. Requests with capture disabled are ignored and not counted.
- Push accepted when request & !lock & (!full_o | pop_eff). Otherwise a request increments drop_count.
- pop_eff = trace_pop_i & trace_ready. A pop while empty is ignored and has no side effects.
- Latency: a packet pushed at edge N is visible on trace_in with trace_ready=1 after edge N (one cycle). trace_in is the registered head entry. After a pop, the next entry is shown from the following cycle.
- Simultaneous push and pop:
  - When full: both occur; occupancy stays DEPTH; no drop.
  - When empty: the pop is ignored and the push is accepted; occupancy becomes 1.
- Pointers wrap modulo DEPTH. occupancy_o = pushes − pops, held in PTR_WIDTH+1 bits. full_o = (occupancy_o==DEPTH).
- high_water updates to occupancy_o whenever the next occupancy exceeds it.
- push_count and drop_count saturate at 32'hFFFF_FFFF with no wrap.
- FSM states:
  - RUN: normal operation.
  - FLUSH: entered from RUN when flush_i=1. In the same edge, pointers, occupancy and high_water clear and trace_ready=0. In the FLUSH cycle, push and pop are ignored and requests are not counted as drops. FLUSH → RUN next cycle, or stays in FLUSH while flush_i is held.
  - flush_i has priority over push and pop in the same cycle. Counters push_count and drop_count are not cleared by flush.
- While lock=1, pops are still honoured so the cache can drain.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge. The first push is possible on the first edge after rst deasserts.

Test Plan:
- Reset then 3 pushes (packets 0xA, 0xB, 0xC in low bits), no pops → trace_ready=1 one cycle after the first push; trace_in low bits=0xA; occupancy_o=3; push_count=3.
- Fill 8, then push 2 more without pop → full_o=1, occupancy_o=8, drop_count=2, high_water=8; pop 8 times → packets emerge in order, then trace_ready=0.
- When full, push+pop in the same cycle → occupancy_o stays 8, drop_count unchanged, and the new packet appears as the 8th entry after 7 further pops. When empty, push+pop in the same cycle → occupancy_o=1.
- lock=1 with 4 push requests and 2 entries buffered, pop asserted twice → drop_count+=4, both entries drained, trace_ready=0. trace_capture_enable=0 with 4 requests → no change to any counter.
- 5 entries buffered, flush_i for 1 cycle with a simultaneous push → occupancy_o=0, high_water=0, trace_ready=0, push_count unchanged; a push next cycle is accepted normally.
- Assert rst asynchronously mid-stream (6 entries buffered) → all outputs 0 before the next clk edge. Preload push_count=32'hFFFF_FFFF (force) then push → value holds at 32'hFFFF_FFFF.
